intc_8src: RTL and testbench



---
 rtl/intc_8src_if.sv | 29 ++
 rtl/intc_8src.sv | 159 +++++++++++++++
 tb/tb_intc_8src.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/intc_8src_if.sv
// intc_8src_if: bus and CPU interrupt handshake between the CPU side and intc_8src.
//   cs/we/addr/wdata : MIO peripheral select, write strobe, word offset, write data
//   rdata            : read data, combinational from addr
//   Ireq/Iack        : interrupt request to the CPU / acknowledge from the CPU
//   cause            : ID of the request presented or in service
// The master modport is the CPU/bus side. The slave modport is the controller.
interface intc_8src_if #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC)
);
    logic            cs;
    logic            we;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            Ireq;
    logic            Iack;
    logic [ID_W-1:0] cause;

    modport master (
        output cs, we, addr, wdata, Iack,
        input  rdata, Ireq, cause
    );

    modport slave (
        input  cs, we, addr, wdata, Iack,
        output rdata, Ireq, cause
    );
endinterface

// File: rtl/intc_8src.sv
// intc_8src: eight-source interrupt controller in front of the CPU Ireq/Iack port.
// It synchronises the asynchronous interrupt lines and detects their rising edges.
// Each edge is latched in a pending register, and a software mask selects which
// sources may raise a request. The controller presents one fixed-priority request
// at a time (the lowest index wins). After that it waits for an EOI write.
//   clk     : system clock, shared with the CPU
//   reset   : asynchronous, active-low reset
//   irq_src : asynchronous interrupt lines, rising-edge triggered
//   bus     : register bus and Ireq/Iack/cause handshake (slave side)
// Register map (word offset):
//   0 PENDING : reads the pending bits. Writing 1 to a bit clears it.
//   1 MASK    : read/write. 1 = source enabled.
//   2 CAUSE   : read-only {in_svc, cause}.
//   3 CTRL    : bit0 = gie (read/write). Writing bit1 = 1 is EOI; bit1 reads 0.
module intc_8src #(
    parameter int N_SRC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_src,
    intc_8src_if.slave        bus
);
    localparam int ID_W = $clog2(N_SRC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;
    logic [N_SRC-1:0] dly_q, dly_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             gie_q, gie_d;
    logic [ID_W-1:0]  cause_q, cause_d;

    logic             wr_en;
    logic             eoi;
    logic             in_svc;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] ack_clr;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic [31-N_SRC:0] wdata_unused;

    // The upper write-data bits have no register behind them.
    assign wdata_unused = bus.wdata[31:N_SRC];

    always_comb begin
        wr_en   = bus.cs && bus.we;
        eoi     = wr_en && (bus.addr == 2'd3) && bus.wdata[1];
        in_svc  = (state_q == ST_SVC);

        sync1_d = irq_src;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        rise    = sync2_q & ~dly_q;

        ack_clr = '0;
        if (state_q == ST_REQ && bus.Iack) begin
            ack_clr[cause_q] = 1'b1;
        end

        // A fresh edge is OR-ed in last, so it wins over a W1C or Iack clear
        // on the same bit in the same cycle.
        pending_d = pending_q & ~ack_clr;
        if (wr_en && bus.addr == 2'd0) begin
            pending_d = pending_d & ~bus.wdata[N_SRC-1:0];
        end
        pending_d = pending_d | rise;

        mask_d = mask_q;
        if (wr_en && bus.addr == 2'd1) begin
            mask_d = bus.wdata[N_SRC-1:0];
        end

        gie_d = gie_q;
        if (wr_en && bus.addr == 2'd3) begin
            gie_d = bus.wdata[0];
        end

        active  = gie_q ? (pending_q & mask_q) : '0;
        win_id  = '0;
        win_vld = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (active[i] && !win_vld) begin
                win_id  = ID_W'(i);
                win_vld = 1'b1;
            end
        end
    end

    // cause is only re-latched in IDLE, so it stays frozen through REQ and SVC.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    cause_d = win_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.Iack) begin
                    state_d = ST_SVC;
                end
            end
            ST_SVC: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            dly_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            dly_q     <= dly_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            cause_q   <= cause_d;
        end
    end

    // Ireq decodes directly from the state flop, so reset drops it at once.
    always_comb begin
        bus.Ireq  = (state_q == ST_REQ);
        bus.cause = cause_q;
        bus.rdata = '0;
        case (bus.addr)
            2'd0: bus.rdata[N_SRC-1:0] = pending_q;
            2'd1: bus.rdata[N_SRC-1:0] = mask_q;
            2'd2: begin
                bus.rdata[ID_W-1:0] = cause_q;
                bus.rdata[ID_W]     = in_svc;
            end
            default: bus.rdata[0] = gie_q;
        endcase
    end
endmodule

// File: tb/tb_intc_8src.sv
// tb_intc_8src: randomized and directed stimulus for intc_8src. The bench checks
// the DUT against a behavioural model that works from the history of sampled
// interrupt lines and from the request and service rules of the controller.
module tb_intc_8src;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq_src = '0;
    logic [7:0] irq_v = '0;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    intc_8src_if #(.N_SRC(8)) bus ();

    intc_8src #(.N_SRC(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Model state: m_st 0 = waiting, 1 = requesting, 2 = in service.
    logic [7:0] m_pend, m_mask;
    logic       m_gie;
    int         m_st;
    logic [2:0] m_cause;
    logic [7:0] h0, h1, h2;  // irq_src sampled at the last three edges (h0 = newest)

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_pend = '0; m_mask = '0; m_gie = 1'b0; m_st = 0; m_cause = '0;
        h0 = '0; h1 = '0; h2 = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'b0, m_pend};
            2'd1:    return {24'b0, m_mask};
            2'd2:    return {28'b0, (m_st == 2), m_cause};
            default: return {31'b0, m_gie};
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, predict the next state,
    // then check the DUT just after the rising edge.
    task automatic step(input bit c, input bit w, input logic [1:0] a,
                        input logic [31:0] d, input bit ack);
        logic [7:0] rise, act, low, np, nm;
        logic       ng;
        int         ns;
        logic [2:0] nc;
        @(negedge clk);
        bus.cs = c; bus.we = w; bus.addr = a; bus.wdata = d; bus.Iack = ack;
        irq_src = irq_v;
        // A line that was low three edges ago and high two edges ago lands in
        // the pending register at this edge.
        rise = h1 & ~h2;
        np = m_pend; nm = m_mask; ng = m_gie; ns = m_st; nc = m_cause;
        if (m_st == 1 && ack) np[m_cause] = 1'b0;
        if (c && w && a == 2'd0) np = np & ~d[7:0];
        if (c && w && a == 2'd1) nm = d[7:0];
        if (c && w && a == 2'd3) ng = d[0];
        np = np | rise;
        case (m_st)
            0: begin
                act = m_gie ? (m_pend & m_mask) : 8'h00;
                if (act != 8'h00) begin
                    low = act & (~act + 8'd1);
                    nc  = 3'($clog2(low));
                    ns  = 1;
                end
            end
            1: if (ack) ns = 2;
            default: if (c && w && a == 2'd3 && d[1]) ns = 0;
        endcase
        @(posedge clk);
        #1;
        if (!reset) begin
            m_clear();
        end else begin
            m_pend = np; m_mask = nm; m_gie = ng; m_st = ns; m_cause = nc;
            h2 = h1; h1 = h0; h0 = irq_v;
        end
        check("ireq",  32'(bus.Ireq),  32'(m_st == 1));
        check("cause", 32'(bus.cause), 32'(m_cause));
        check("rdata", bus.rdata,      m_read(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b1, 1'b0, a, 32'd0, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_v = v;
        idle(1);
        irq_v = '0;
        idle(3);
    endtask

    initial begin
        m_clear();
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.Iack = 1'b0;

        // Reset held while the lines toggle.
        irq_v = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i));
            check("rst_rdata", bus.rdata, 32'h0);
            check("rst_ireq", 32'(bus.Ireq), 32'h0);
        end
        reset = 1'b1;
        idle(5);
        check("post_rst_ireq", 32'(bus.Ireq), 32'h0);
        irq_v = 8'h00;
        idle(2);
        wr(2'd0, 32'hFF);

        // Basic path.
        wr(2'd1, 32'h04);
        wr(2'd3, 32'h01);
        pulse(8'h04);
        check("basic_ireq", 32'(bus.Ireq), 32'h1);
        check("basic_cause", 32'(bus.cause), 32'h2);
        step(1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
        check("basic_ack_ireq", 32'(bus.Ireq), 32'h0);
        check("basic_pend", bus.rdata, 32'h0);
        rd(2'd2);
        check("basic_cause_svc", bus.rdata, 32'h0000000A);
        wr(2'd3, 32'h3);
        rd(2'd2);
        check("basic_cause_eoi", bus.rdata, 32'h00000002);

        // Priority.
        wr(2'd1, 32'hFF);
        pulse(8'h22);
        check("prio_first", 32'(bus.cause), 32'h1);
        ack();
        wr(2'd3, 32'h3);
        idle(1);
        check("prio_second_ireq", 32'(bus.Ireq), 32'h1);
        check("prio_second", 32'(bus.cause), 32'h5);
        ack();
        wr(2'd3, 32'h3);

        // Masking.
        wr(2'd1, 32'h00);
        irq_v = 8'h08; idle(1); irq_v = 8'h00;
        for (int i = 0; i < 3; i++) rd(2'd0);
        check("mask_pend", bus.rdata, 32'h08);
        check("mask_noreq", 32'(bus.Ireq), 32'h0);
        wr(2'd1, 32'h08);
        idle(1);
        check("mask_ireq", 32'(bus.Ireq), 32'h1);
        ack();
        irq_v = 8'h08; idle(1); irq_v = 8'h00; idle(1);
        rd(2'd0);
        check("svc_edge_pend", bus.rdata, 32'h08);
        step(1'b1, 1'b1, 2'd0, 32'h08, 1'b0);
        check("svc_w1c", bus.rdata, 32'h0);
        wr(2'd3, 32'h3);

        // Edge and Iack clear on source 0 in the same cycle.
        wr(2'd1, 32'h01);
        pulse(8'h01);
        check("coll_first", 32'(bus.Ireq), 32'h1);
        irq_v = 8'h01;
        idle(2);
        step(1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
        check("coll_pend", bus.rdata, 32'h01);
        irq_v = 8'h00;
        wr(2'd3, 32'h3);
        idle(1);
        check("coll_second_ireq", 32'(bus.Ireq), 32'h1);
        check("coll_second_cause", 32'(bus.cause), 32'h0);
        ack();
        wr(2'd3, 32'h3);

        // Reset asserted while requesting.
        pulse(8'h01);
        check("arst_pre", 32'(bus.Ireq), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ireq", 32'(bus.Ireq), 32'h0);
        m_clear();
        idle(2);
        reset = 1'b1;
        rd(2'd1);
        check("arst_mask", bus.rdata, 32'h0);
        check("arst_idle", 32'(bus.Ireq), 32'h0);

        // Randomized traffic.
        wr(2'd3, 32'h1);
        for (int n = 0; n < 3000; n++) begin
            bit          c, w, k;
            logic [1:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 5) == 0) irq_v = irq_v ^ 8'(1 << $urandom_range(0, 7));
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            c = 1'($urandom_range(0, 1));
            w = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                c = ($urandom_range(0, 3) != 0);
                w = 1'b1;
                if (a == 2'd3) d[0] = ($urandom_range(0, 3) != 0);
            end
            if (m_st == 2 && $urandom_range(0, 3) == 0) begin
                c = 1'b1; w = 1'b1; a = 2'd3; d = 32'h3;
            end
            k = (m_st == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            step(c, w, a, d, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
